// File: rtl/ascon_host_seq.sv
// Host-side sequencer for the Ascon core: turns one job command plus a flat
// word stream into the core's key/bdi/bdo/auth traffic and returns its output.
module ascon_host_seq #(
    parameter int CCW   = 32,
    parameter int CCSW  = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_new_key,
    input  logic [LEN_W-1:0] cmd_ad_len,
    input  logic [LEN_W-1:0] cmd_msg_len,
    input  logic [CCW-1:0]   in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [CCW-1:0]   out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_type,
    output logic             out_last,
    output logic             done,
    output logic             done_auth,
    output logic             done_err,
    output logic             busy,
    output logic [CCSW-1:0]  key,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [CCW-1:0]   bdi,
    output logic             bdi_valid,
    input  logic             bdi_ready,
    output logic [3:0]       bdi_type,
    output logic             bdi_eot,
    output logic             bdi_eoi,
    output logic             decrypt,
    output logic             hash,
    input  logic [CCW-1:0]   bdo,
    input  logic             bdo_valid,
    output logic             bdo_ready,
    input  logic [3:0]       bdo_type,
    input  logic             bdo_eot,
    input  logic             auth,
    input  logic             auth_valid,
    output logic             auth_ready
);

    localparam logic [3:0] D_NULL  = 4'd0;
    localparam logic [3:0] D_NONCE = 4'd1;
    localparam logic [3:0] D_AD    = 4'd2;
    localparam logic [3:0] D_PTCT  = 4'd3;
    localparam logic [3:0] D_TAG   = 4'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_KEY, S_NONCE, S_AD, S_PTCT,
        S_TAGI, S_TAGO, S_HOUT, S_AUTH, S_FIN
    } state_t;

    state_t           state;
    state_t           tag_st;
    state_t           msg_st;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] ad_len;
    logic [LEN_W-1:0] msg_len;
    logic             last;
    logic             in_xfer;
    logic             out_xfer;

    assign tag_st    = decrypt ? S_TAGI : S_TAGO;
    assign msg_st    = (msg_len != '0) ? S_PTCT : tag_st;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign cmd_ready = (state == S_IDLE) && !rst;
    assign busy      = (state != S_IDLE);

    // Data passthroughs are forced to zero outside their owning states.
    always_comb begin
        key        = '0;
        key_valid  = 1'b0;
        bdi        = '0;
        bdi_valid  = 1'b0;
        bdi_type   = D_NULL;
        bdi_eot    = 1'b0;
        bdi_eoi    = 1'b0;
        in_ready   = 1'b0;
        out_data   = '0;
        out_valid  = 1'b0;
        out_type   = D_NULL;
        out_last   = 1'b0;
        bdo_ready  = 1'b0;
        auth_ready = 1'b0;
        last       = 1'b0;
        unique case (state)
            S_KEY: begin
                key       = in_data;
                key_valid = in_valid;
                in_ready  = key_ready;
                last      = (cnt == LEN_W'(3));
            end
            S_NONCE: begin
                bdi       = in_data;
                bdi_valid = in_valid;
                in_ready  = bdi_ready;
                bdi_type  = D_NONCE;
                last      = (cnt == LEN_W'(3));
                bdi_eot   = last;
                bdi_eoi   = last && (ad_len == '0) && (msg_len == '0);
            end
            S_AD: begin
                bdi       = in_data;
                bdi_valid = in_valid;
                in_ready  = bdi_ready;
                bdi_type  = D_AD;
                last      = (cnt == ad_len - LEN_W'(1));
                bdi_eot   = last;
                bdi_eoi   = last && (hash || (msg_len == '0));
            end
            S_PTCT: begin
                bdi       = in_data;
                bdi_valid = in_valid;
                in_ready  = bdi_ready & out_ready;
                bdi_type  = D_PTCT;
                last      = (cnt == msg_len - LEN_W'(1));
                bdi_eot   = last;
                bdi_eoi   = last;
                out_data  = bdo;
                out_valid = bdo_valid;
                out_type  = bdo_type;
                bdo_ready = out_ready;
            end
            S_TAGI: begin
                bdi       = in_data;
                bdi_valid = in_valid;
                in_ready  = bdi_ready;
                bdi_type  = D_TAG;
                last      = (cnt == LEN_W'(3));
                bdi_eot   = last;
            end
            S_TAGO, S_HOUT: begin
                out_data  = bdo;
                out_valid = bdo_valid;
                out_type  = bdo_type;
                out_last  = bdo_eot;
                bdo_ready = out_ready;
            end
            S_AUTH: auth_ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ad_len    <= '0;
            msg_len   <= '0;
            decrypt   <= 1'b0;
            hash      <= 1'b0;
            done      <= 1'b0;
            done_auth <= 1'b0;
            done_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (in_xfer)
                cnt <= cnt + LEN_W'(1);
            unique case (state)
                S_IDLE: if (cmd_valid) begin
                    ad_len    <= cmd_ad_len;
                    msg_len   <= cmd_msg_len;
                    cnt       <= '0;
                    done_auth <= 1'b0;
                    done_err  <= 1'b0;
                    if (cmd_op == 2'd3 || (cmd_op == 2'd2 && cmd_ad_len == '0)) begin
                        done_err <= 1'b1;
                        done     <= 1'b1;
                        state    <= S_FIN;
                    end else if (cmd_op == 2'd2) begin
                        hash  <= 1'b1;
                        state <= S_AD;
                    end else begin
                        decrypt <= cmd_op[0];
                        state   <= cmd_new_key ? S_KEY : S_NONCE;
                    end
                end
                S_KEY: if (in_xfer && last) begin
                    cnt   <= '0;
                    state <= S_NONCE;
                end
                S_NONCE: if (in_xfer && last) begin
                    cnt   <= '0;
                    state <= (ad_len != '0) ? S_AD : msg_st;
                end
                S_AD: if (in_xfer && last) begin
                    cnt   <= '0;
                    state <= hash ? S_HOUT : msg_st;
                end
                S_PTCT: if (in_xfer && last) begin
                    cnt   <= '0;
                    state <= tag_st;
                end
                S_TAGI: if (in_xfer && last) begin
                    cnt   <= '0;
                    state <= S_AUTH;
                end
                S_TAGO, S_HOUT: if (out_xfer && bdo_eot) begin
                    done  <= 1'b1;
                    state <= S_FIN;
                end
                S_AUTH: if (auth_valid) begin
                    done_auth <= auth;
                    done      <= 1'b1;
                    state     <= S_FIN;
                end
                S_FIN: begin
                    cnt     <= '0;
                    decrypt <= 1'b0;
                    hash    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_host_seq.sv
// Bench for ascon_host_seq: a toy core (XOR keystream, XOR-fold tag/hash)
// sits on the core side so every expected word is easy to derive by hand.
module tb_ascon_host_seq;

    localparam logic [3:0] D_NONCE = 4'd1;
    localparam logic [3:0] D_PTCT  = 4'd3;
    localparam logic [3:0] D_TAG   = 4'd4;
    localparam logic [3:0] D_HASH  = 4'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic        cmd_new_key = 1'b0;
    logic [15:0] cmd_ad_len = '0, cmd_msg_len = '0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] out_data;
    logic        out_valid, out_ready = 1'b1;
    logic [3:0]  out_type;
    logic        out_last, done, done_auth, done_err, busy;
    logic [31:0] key, bdi, bdo;
    logic        key_valid, key_ready, bdi_valid, bdi_ready;
    logic [3:0]  bdi_type, bdo_type;
    logic        bdi_eot, bdi_eoi, decrypt, hash;
    logic        bdo_valid, bdo_ready, bdo_eot;
    logic        auth, auth_valid, auth_ready;

    always #5 clk = ~clk;

    ascon_host_seq dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_new_key(cmd_new_key), .cmd_ad_len(cmd_ad_len),
        .cmd_msg_len(cmd_msg_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_type(out_type), .out_last(out_last),
        .done(done), .done_auth(done_auth), .done_err(done_err), .busy(busy),
        .key(key), .key_valid(key_valid), .key_ready(key_ready),
        .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(bdi_ready),
        .bdi_type(bdi_type), .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi),
        .decrypt(decrypt), .hash(hash),
        .bdo(bdo), .bdo_valid(bdo_valid), .bdo_ready(bdo_ready),
        .bdo_type(bdo_type), .bdo_eot(bdo_eot),
        .auth(auth), .auth_valid(auth_valid), .auth_ready(auth_ready)
    );

    // Toy core: ct = pt ^ last key word; tag/hash word i = fold ^ i*01010101.
    logic [31:0] kreg, acc, m_w;
    logic [1:0]  m_ph;
    logic [2:0]  oi, ti;
    logic        fresh, tag_ok;

    function automatic logic [31:0] mix(input logic [31:0] a, input logic [2:0] i);
        return a ^ (32'h01010101 * {29'd0, i});
    endfunction

    assign key_ready  = 1'b1;
    assign auth_valid = (m_ph == 2'd3);
    assign auth       = tag_ok;
    assign m_w        = (bdi_type == D_PTCT && !decrypt) ? (bdi ^ kreg) : bdi;

    always_comb begin
        bdi_ready = 1'b0;
        bdo       = '0;
        bdo_valid = 1'b0;
        bdo_type  = 4'd0;
        bdo_eot   = 1'b0;
        if (m_ph == 2'd0) begin
            bdi_ready = (bdi_type == D_PTCT) ? bdo_ready : 1'b1;
            if (bdi_type == D_PTCT) begin
                bdo_valid = bdi_valid;
                bdo       = bdi ^ kreg;
                bdo_type  = D_PTCT;
                bdo_eot   = bdi_eot;
            end
        end else if (m_ph == 2'd1) begin
            bdo_valid = 1'b1;
            bdo       = mix(acc, oi);
            bdo_type  = D_TAG;
            bdo_eot   = (oi == 3'd3);
        end else if (m_ph == 2'd2) begin
            bdo_valid = 1'b1;
            bdo       = mix(acc, oi);
            bdo_type  = D_HASH;
            bdo_eot   = (oi == 3'd7);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= '0; kreg <= '0; acc <= '0; fresh <= 1'b1;
            tag_ok <= 1'b1; ti <= '0; oi <= '0;
        end else begin
            if (key_valid && key_ready) kreg <= key;
            if (m_ph == 2'd0 && bdi_valid && bdi_ready) begin
                if (bdi_type == D_TAG) begin
                    tag_ok <= tag_ok & (bdi == mix(acc, ti));
                    ti <= ti + 3'd1;
                    if (bdi_eot) m_ph <= 2'd3;
                end else begin
                    acc <= fresh ? m_w : (acc ^ m_w);
                    if (fresh) begin tag_ok <= 1'b1; ti <= '0; end
                    fresh <= 1'b0;
                    if (bdi_eoi) begin
                        oi <= '0;
                        if (hash) m_ph <= 2'd2;
                        else if (!decrypt) m_ph <= 2'd1;
                    end
                end
            end
            if ((m_ph == 2'd1 || m_ph == 2'd2) && bdo_valid && bdo_ready) begin
                oi <= oi + 3'd1;
                if (bdo_eot) begin m_ph <= 2'd0; fresh <= 1'b1; end
            end
            if (m_ph == 2'd3 && auth_ready) begin m_ph <= 2'd0; fresh <= 1'b1; end
        end
    end

    int n_checks = 0, n_fail = 0;
    logic [31:0] in_q[$];
    logic [31:0] o_data[$];
    logic [3:0]  o_type[$];
    logic        o_last[$];
    int  eoi_at, eoi_cnt, bdi_n, done_cyc, acc_cyc, last_cyc, stall_viol, cyc;
    bit  got_done, ready_seen;
    logic d_auth, d_err;

    task automatic run_job(input logic [1:0] op, input logic nk, input logic [15:0] ad,
                           input logic [15:0] msg, input int stall_at, input int budget);
        bit pop_p = 0, stall_started = 0;
        int stall_left = 0;
        o_data.delete(); o_type.delete(); o_last.delete();
        eoi_at = -1; eoi_cnt = 0; bdi_n = 0; got_done = 0; done_cyc = -1;
        acc_cyc = -1; last_cyc = -1; stall_viol = 0; ready_seen = 0; cyc = 0;
        d_auth = 1'bx; d_err = 1'bx;
        cmd_op = op; cmd_new_key = nk; cmd_ad_len = ad; cmd_msg_len = msg;
        cmd_valid = 1'b1;
        while (!got_done && cyc < budget) begin
            @(negedge clk);
            if (pop_p) begin void'(in_q.pop_front()); pop_p = 0; end
            if (acc_cyc >= 0) cmd_valid = 1'b0;
            if (stall_at >= 0 && !stall_started && o_data.size() == stall_at) begin
                stall_started = 1; stall_left = 5;
            end
            out_ready = (stall_left == 0);
            in_valid  = (in_q.size() > 0);
            in_data   = in_valid ? in_q[0] : '0;
            #1;
            if (stall_left > 0) begin
                if (in_ready) stall_viol++;
                stall_left--;
            end
            if (in_ready) ready_seen = 1;
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (in_valid && in_ready) pop_p = 1;
            if (bdi_valid && bdi_ready) begin
                if (bdi_eoi) begin eoi_cnt++; eoi_at = bdi_n; end
                bdi_n++;
            end
            if (out_valid && out_ready) begin
                o_data.push_back(out_data); o_type.push_back(out_type);
                o_last.push_back(out_last);
                if (out_last) last_cyc = cyc;
            end
            if (done) begin
                got_done = 1; done_cyc = cyc; d_auth = done_auth; d_err = done_err;
            end
            cyc++;
        end
        if (pop_p) void'(in_q.pop_front());
        cmd_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic load_nonce();
        in_q.push_back(32'h10111213); in_q.push_back(32'h14151617);
        in_q.push_back(32'h18191A1B); in_q.push_back(32'h1C1D1E1F);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #3;
        n_checks++;
        if ({cmd_ready, in_ready, key_valid, bdi_valid, out_valid, done, busy,
             done_err, done_auth, decrypt, hash, bdi_type} !== 15'd0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero, expected all 0");
        end
        @(negedge clk) rst = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL idle_cmd_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_encrypt_kat(input string tag);
        logic [31:0] ed [6] = '{32'h3C3C3C3C, 32'h38383878, 32'h00000040,
                                32'h01010141, 32'h02020242, 32'h03030343};
        in_q.delete();
        in_q.push_back(32'h00010203); in_q.push_back(32'h04050607);
        in_q.push_back(32'h08090A0B); in_q.push_back(32'h0C0D0E0F);
        load_nonce();
        in_q.push_back(32'h20212223); in_q.push_back(32'h24252627);
        in_q.push_back(32'h30313233); in_q.push_back(32'h34353677);
        run_job(2'd0, 1'b1, 16'd2, 16'd2, -1, 200);
        n_checks++;
        if (!got_done) begin n_fail++; $display("FAIL %s_timeout: no done", tag); end
        n_checks++;
        if (in_q.size() != 0 || o_data.size() != 6) begin
            n_fail++;
            $display("FAIL %s_counts: left %0d out %0d expected 0/6", tag, in_q.size(), o_data.size());
        end
        for (int i = 0; i < 6; i++) if (i < o_data.size()) begin
            n_checks++;
            if (o_data[i] !== ed[i] || o_type[i] !== ((i < 2) ? D_PTCT : D_TAG)
                || o_last[i] !== (i == 5)) begin
                n_fail++;
                $display("FAIL %s_out%0d: got %h/%0d/%b expected %h", tag, i,
                         o_data[i], o_type[i], o_last[i], ed[i]);
            end
        end
        n_checks++;
        if (eoi_at != 7 || eoi_cnt != 1) begin
            n_fail++; $display("FAIL %s_eoi: at %0d n %0d expected 7/1", tag, eoi_at, eoi_cnt);
        end
        n_checks++;
        if (done_cyc - last_cyc != 1) begin
            n_fail++; $display("FAIL %s_done_lat: got %0d expected 1", tag, done_cyc - last_cyc);
        end
        n_checks++;
        if (d_err !== 1'b0) begin n_fail++; $display("FAIL %s_err: got %b expected 0", tag, d_err); end
    endtask

    task automatic test_decrypt(input logic flip, input logic exp_auth);
        in_q.delete();
        load_nonce();
        in_q.push_back(32'h20212223); in_q.push_back(32'h24252627);
        in_q.push_back(32'h3C3C3C3C); in_q.push_back(32'h38383878);
        in_q.push_back(32'h00000040 ^ {31'd0, flip}); in_q.push_back(32'h01010141);
        in_q.push_back(32'h02020242); in_q.push_back(32'h03030343);
        run_job(2'd1, 1'b0, 16'd2, 16'd2, -1, 200);
        n_checks++;
        if (!got_done || o_data.size() != 2) begin
            n_fail++; $display("FAIL dec_done: done %b out %0d expected 1/2", got_done, o_data.size());
        end
        if (o_data.size() == 2) begin
            n_checks++;
            if (o_data[0] !== 32'h30313233 || o_data[1] !== 32'h34353677 || o_last[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL dec_pt: got %h %h expected 30313233 34353677", o_data[0], o_data[1]);
            end
        end
        n_checks++;
        if (d_auth !== exp_auth) begin
            n_fail++; $display("FAIL dec_auth: got %b expected %b", d_auth, exp_auth);
        end
    endtask

    task automatic test_hash();
        in_q.delete();
        in_q.push_back(32'h80000000);
        run_job(2'd2, 1'b0, 16'd1, 16'd0, -1, 200);
        n_checks++;
        if (!got_done || o_data.size() != 8) begin
            n_fail++; $display("FAIL hash_done: done %b out %0d expected 1/8", got_done, o_data.size());
        end
        for (int i = 0; i < 8; i++) if (i < o_data.size()) begin
            n_checks++;
            if (o_data[i] !== (32'h80000000 ^ (32'h01010101 * i)) || o_type[i] !== D_HASH
                || o_last[i] !== (i == 7)) begin
                n_fail++;
                $display("FAIL hash_out%0d: got %h/%0d/%b", i, o_data[i], o_type[i], o_last[i]);
            end
        end
        n_checks++;
        if (eoi_at != 0) begin n_fail++; $display("FAIL hash_eoi: got %0d expected 0", eoi_at); end
    endtask

    task automatic test_empty_msg();
        in_q.delete();
        load_nonce();
        run_job(2'd0, 1'b0, 16'd0, 16'd0, -1, 200);
        n_checks++;
        if (!got_done || o_data.size() != 4) begin
            n_fail++; $display("FAIL empty_done: done %b out %0d expected 1/4", got_done, o_data.size());
        end
        for (int i = 0; i < 4; i++) if (i < o_data.size()) begin
            n_checks++;
            if (o_data[i] !== (32'h01010101 * i) || o_type[i] !== D_TAG) begin
                n_fail++; $display("FAIL empty_tag%0d: got %h/%0d", i, o_data[i], o_type[i]);
            end
        end
        n_checks++;
        if (eoi_at != 3 || eoi_cnt != 1) begin
            n_fail++; $display("FAIL empty_eoi: at %0d n %0d expected 3/1", eoi_at, eoi_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ed [8] = '{32'h3C3C3C3C, 32'h38383878, 32'h0D0F0D0B, 32'hACBDCEDF,
                                32'hA5B6C790, 32'hA4B7C691, 32'hA7B4C592, 32'hA6B5C493};
        logic [31:0] ref_q[$];
        for (int pass = 0; pass < 2; pass++) begin
            in_q.delete();
            load_nonce();
            in_q.push_back(32'h30313233); in_q.push_back(32'h34353677);
            in_q.push_back(32'h01020304); in_q.push_back(32'hA0B0C0D0);
            run_job(2'd0, 1'b0, 16'd0, 16'd4, (pass == 1) ? 2 : -1, 300);
            if (pass == 0) ref_q = o_data;
            n_checks++;
            if (!got_done || o_data.size() != 8) begin
                n_fail++; $display("FAIL bp%0d_count: out %0d expected 8", pass, o_data.size());
            end
            for (int i = 0; i < 8; i++) if (i < o_data.size()) begin
                n_checks++;
                if (o_data[i] !== ed[i]) begin
                    n_fail++; $display("FAIL bp%0d_out%0d: got %h expected %h", pass, i, o_data[i], ed[i]);
                end
            end
        end
        n_checks++;
        if (stall_viol != 0) begin
            n_fail++; $display("FAIL bp_in_ready: high in %0d stall cycles, expected 0", stall_viol);
        end
        n_checks++;
        if (o_data != ref_q) begin n_fail++; $display("FAIL bp_vs_ref: stalled stream differs"); end
    endtask

    task automatic test_errors();
        for (int k = 0; k < 2; k++) begin
            in_q.delete();
            run_job((k == 0) ? 2'd3 : 2'd2, 1'b0, (k == 0) ? 16'd1 : 16'd0, 16'd1, -1, 10);
            n_checks++;
            if (!got_done || d_err !== 1'b1 || done_cyc - acc_cyc != 1) begin
                n_fail++;
                $display("FAIL err%0d: done %b err %b lat %0d expected 1/1/1", k, got_done, d_err,
                         done_cyc - acc_cyc);
            end
            n_checks++;
            if (ready_seen || o_data.size() != 0 || bdi_n != 0) begin
                n_fail++; $display("FAIL err%0d_traffic: in_ready %b out %0d bdi %0d expected 0",
                                   k, ready_seen, o_data.size(), bdi_n);
            end
        end
    endtask

    task automatic test_reset_mid_job();
        in_q.delete();
        load_nonce();
        in_q.push_back(32'h30313233); in_q.push_back(32'h34353677);
        in_q.push_back(32'h01020304); in_q.push_back(32'hA0B0C0D0);
        run_job(2'd0, 1'b0, 16'd0, 16'd4, -1, 7);
        n_checks++;
        if (bdi_type !== D_PTCT || busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_state: type %0d busy %b expected 3/1", bdi_type, busy);
        end
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({cmd_ready, in_ready, key_valid, bdi_valid, bdi_eot, bdi_eoi, out_valid, out_last,
             bdo_ready, auth_ready, done, busy, decrypt, hash, bdi_type, out_type} !== 22'd0
            || {key, bdi, out_data} !== 96'd0) begin
            n_fail++; $display("FAIL mid_reset: outputs not all 0 under reset");
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_data = '0;
        test_encrypt_kat("post_rst");
    endtask

    initial begin
        test_reset();
        test_encrypt_kat("enc");
        test_decrypt(1'b0, 1'b1);
        test_decrypt(1'b1, 1'b0);
        test_hash();
        test_empty_msg();
        test_backpressure();
        test_errors();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
